// File: rtl/and3_sweep_ctrl.sv
// Self-test sequencer for the 3-input AND gate: walks x/y/v through 000..111,
// samples z after a settle time and records mismatch count and first failure.
//
// state  | meaning
// IDLE   | waiting for start; x/y/v parked at 000
// SETTLE | vector driven, counting SETTLE_CYCLES before sampling z
// CHECK  | one cycle; z sampled and compared at the closing edge
// DONE   | one-cycle completion pulse, pass verdict latched
module and3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       v,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic       r_fv;
    logic [2:0] r_ff;

    logic       w_expect;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    assign w_expect   = (r_idx == 3'd7);
    assign w_mismatch = (z != w_expect);
    // includes a mismatch found in the final CHECK so the pass verdict sees it
    assign w_err_next = r_err + {3'b000, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_fv    <= 1'b0;
            r_ff    <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_idx   <= 3'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_err   <= 4'd0;
                        r_fv    <= 1'b0;
                        r_ff    <= 3'd0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    // an aborted CHECK is discarded entirely; partial results hold
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            r_err <= w_err_next;
                            if (!r_fv) begin
                                r_fv <= 1'b1;
                                r_ff <= r_idx;
                            end
                        end
                        if (r_idx == 3'd7) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_cnt   <= 4'd0;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idx   <= 3'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x          = r_idx[2];
    assign y          = r_idx[1];
    assign v          = r_idx[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fv;
    assign first_fail = r_ff;

endmodule

// File: tb/tb_and3_sweep_ctrl.sv
// Bench for and3_sweep_ctrl: two instances (settle 1 and 3) with a selectable
// gate model; sweep results are checked by done-pulse monitors against a queue.
module tb_and3_sweep_ctrl;

    typedef struct {
        bit       pass;
        int       err;
        bit       fv;
        int       ff;
        int       done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, abort, z;
    logic [1:0] x, y, v, busy, done, pass, fv;
    logic [3:0] err0, err1;
    logic [2:0] ff0, ff1;
    logic [1:0] d1 = 2'b00;
    logic [1:0] d2 = 2'b00;
    int         gmode [2];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    exp_t       q0 [$];
    exp_t       q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    and3_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .z(z[0]),
        .x(x[0]), .y(y[0]), .v(v[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err0), .fail_valid(fv[0]), .first_fail(ff0)
    );

    and3_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .z(z[1]),
        .x(x[1]), .y(y[1]), .v(v[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err1), .fail_valid(fv[1]), .first_fail(ff1)
    );

    // gate models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 two-cycle delay
    function automatic logic gate_z(input int m, input logic a, input logic dl);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return dl;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) begin
        d1 <= x & y & v;
        d2 <= d1;
    end
    assign z[0] = gate_z(gmode[0], x[0] & y[0] & v[0], d2[0]);
    assign z[1] = gate_z(gmode[1], x[1] & y[1] & v[1], d2[1]);

    function automatic int get_err(input int d);
        return (d == 0) ? int'(err0) : int'(err1);
    endfunction
    function automatic int get_ff(input int d);
        return (d == 0) ? int'(ff0) : int'(ff1);
    endfunction
    function automatic int get_xyv(input int d);
        return int'({x[d], y[d], v[d]});
    endfunction
    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    function automatic exp_t mk(input bit p, input int e, input bit f, input int ffv);
        exp_t r;
        r.pass = p; r.err = e; r.fv = f; r.ff = ffv; r.done_cyc = 0;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input int d, input exp_t e);
        chk($sformatf("dut%0d pass", d), int'(pass[d]), int'(e.pass));
        chk($sformatf("dut%0d err_count", d), get_err(d), e.err);
        chk($sformatf("dut%0d fail_valid", d), int'(fv[d]), int'(e.fv));
        if (e.fv) chk($sformatf("dut%0d first_fail", d), get_ff(d), e.ff);
        chk($sformatf("dut%0d done cycle", d), cyc, e.done_cyc);
        chk($sformatf("dut%0d busy at done", d), int'(busy[d]), 0);
    endtask

    task automatic unexpected_done(input int d);
        checks++;
        fails++;
        $display("FAIL dut%0d done: got unexpected pulse expected none (cycle %0d)", d, cyc);
    endtask

    // monitors: one per instance, fire on the done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done[0]) begin
            if (q0.size() == 0) unexpected_done(0);
            else begin
                e = q0.pop_front();
                check_done(0, e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done[1]) begin
            if (q1.size() == 0) unexpected_done(1);
            else begin
                e = q1.pop_front();
                check_done(1, e);
            end
        end
    end

    task automatic check_reset(input int d);
        chk($sformatf("dut%0d reset x/y/v", d), get_xyv(d), 0);
        chk($sformatf("dut%0d reset flags", d),
            int'({busy[d], done[d], pass[d], fv[d]}), 0);
        chk($sformatf("dut%0d reset err_count", d), get_err(d), 0);
        chk($sformatf("dut%0d reset first_fail", d), get_ff(d), 0);
    endtask

    // called at a negedge; returns at the negedge of the first cycle after acceptance
    task automatic launch(input int d, input int s, input exp_t e, input bit push);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + 8 * (s + 1);
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (qsize(d) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            checks++;
            fails++;
            $display("FAIL dut%0d done timeout: got no pulse expected one", d);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done[d]) begin
            checks++;
            fails++;
            $display("FAIL dut%0d done wait: got timeout expected pulse", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 2'b00;
        abort = 2'b00;
        gmode[0] = 0;
        gmode[1] = 0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        // ideal gate, vector trace and busy window
        launch(0, 1, mk(1, 0, 0, 0), 1'b1);
        for (int n = 1; n <= 16; n++) begin
            chk($sformatf("trace vector c%0d", n), get_xyv(0), (n - 1) / 2);
            chk($sformatf("trace busy c%0d", n), int'(busy[0]), 1);
            @(negedge clk);
        end
        wait_drain(0);

        gmode[0] = 1;
        launch(0, 1, mk(0, 1, 1, 7), 1'b1);
        wait_drain(0);

        // stuck-at-1, then a start in the cycle right after done
        gmode[0] = 2;
        launch(0, 1, mk(0, 7, 1, 0), 1'b1);
        wait_done(0);
        @(negedge clk);
        launch(0, 1, mk(0, 7, 1, 0), 1'b1);
        chk("restart clears err_count", get_err(0), 0);
        chk("restart clears fail_valid", int'(fv[0]), 0);
        wait_drain(0);

        gmode[1] = 3;
        launch(1, 3, mk(1, 0, 0, 0), 1'b1);
        wait_drain(1);

        // two-cycle delay with settle 1: only vector 7 sees the stale 0
        gmode[0] = 3;
        launch(0, 1, mk(0, 1, 1, 7), 1'b1);
        wait_drain(0);

        gmode[0] = 0;
        launch(0, 1, mk(1, 0, 0, 0), 1'b1);
        repeat (6) @(negedge clk);
        chk("restart point vector", get_xyv(0), 3);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_drain(0);
        repeat (20) @(negedge clk);

        gmode[0] = 2;
        launch(0, 1, mk(0, 0, 0, 0), 1'b0);
        repeat (8) @(negedge clk);
        chk("abort point vector", get_xyv(0), 4);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort busy", int'(busy[0]), 0);
        chk("abort x/y/v", get_xyv(0), 0);
        chk("abort pass", int'(pass[0]), 0);
        chk("abort err_count held", get_err(0), 4);
        chk("abort fail_valid held", int'(fv[0]), 1);
        chk("abort first_fail held", get_ff(0), 0);
        repeat (30) @(negedge clk);

        launch(0, 1, mk(0, 0, 0, 0), 1'b0);
        repeat (10) @(negedge clk);
        chk("reset point vector", get_xyv(0), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        gmode[0] = 0;
        @(negedge clk);
        launch(0, 1, mk(1, 0, 0, 0), 1'b1);
        wait_drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
